// File: rtl/alu_slice_exec_if.sv
// Handshake bundle for the slice-serial ALU: operand/code request
// and result response, each on its own valid/ready pair.
interface alu_slice_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid,
        input  in_ready,
        output alu_control,
        output src_a,
        output src_b,
        input  out_valid,
        output out_ready,
        input  result,
        input  zero,
        input  illegal
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  alu_control,
        input  src_a,
        input  src_b,
        output out_valid,
        input  out_ready,
        output result,
        output zero,
        output illegal
    );
endinterface

// File: rtl/alu_slice_exec.sv
// Area-reduced ALU: processes SLICE bits per cycle, LSB slice first,
// with a ripple carry held between slices.
module alu_slice_exec #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic             clk,
    input logic             rst_n,
    alu_slice_exec_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_code;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_zero;
    logic             r_illegal;

    logic             w_accept;
    logic             w_last;
    logic             w_add;
    logic             w_sub;
    logic             w_and;
    logic             w_or;
    logic             w_slt;
    logic             w_legal;
    logic             w_inv;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_sout;
    logic [SLICE:0]   w_sum;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_final;
    logic             w_ovf;
    logic             w_less;

    assign w_add   = (r_code == 3'b000);
    assign w_sub   = (r_code == 3'b001);
    assign w_and   = (r_code == 3'b010);
    assign w_or    = (r_code == 3'b011);
    assign w_slt   = (r_code == 3'b101);
    assign w_legal = w_add | w_sub | w_and | w_or | w_slt;
    assign w_inv   = w_sub | w_slt;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_last   = (r_cnt == LAST);

    assign w_sa  = r_a[int'(r_cnt)*SLICE +: SLICE];
    assign w_sb  = r_b[int'(r_cnt)*SLICE +: SLICE];
    assign w_sum = {1'b0, w_sa}
                 + {1'b0, (w_inv ? ~w_sb : w_sb)}
                 + {{SLICE{1'b0}}, r_carry};

    always_comb begin
        w_sout = '0;
        unique case (1'b1)
            w_and:               w_sout = w_sa & w_sb;
            w_or:                w_sout = w_sa | w_sb;
            w_add, w_sub, w_slt: w_sout = w_sum[SLICE-1:0];
            default:             w_sout = '0;
        endcase
    end

    // Signed compare from the top slice of a - b plus overflow correction
    assign w_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1])
                  & (w_sout[SLICE-1] != r_a[WIDTH-1]);
    assign w_less = w_sout[SLICE-1] ^ w_ovf;

    always_comb begin
        w_merged = r_result;
        w_merged[int'(r_cnt)*SLICE +: SLICE] = w_sout;
        if (!w_legal)
            w_final = '0;
        else if (w_slt)
            w_final = WIDTH'(w_less);
        else
            w_final = w_merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)      w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  bus.in_ready  = rst_n;
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_code    <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_a     <= bus.src_a;
                r_b     <= bus.src_b;
                r_code  <= bus.alu_control;
                r_cnt   <= '0;
                r_carry <= (bus.alu_control == 3'b001)
                         | (bus.alu_control == 3'b101);
            end
        end else if (r_state == S_RUN) begin
            r_carry <= w_sum[SLICE];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_result  <= w_final;
                r_zero    <= (w_final == '0);
                r_illegal <= ~w_legal;
            end else begin
                r_result  <= w_merged;
            end
        end
    end

    assign bus.result  = r_result;
    assign bus.zero    = r_zero;
    assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_alu_slice_exec.sv
// Bench for alu_slice_exec: directed table, random ops against an
// arithmetic model, plus backpressure and mid-run reset sequences.
module tb_alu_slice_exec;
    localparam int W  = 32;
    localparam int NS = 4;

    typedef struct {
        logic [2:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ill;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    alu_slice_exec_if #(.WIDTH(W)) bus ();

    alu_slice_exec #(.WIDTH(W), .SLICE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] c,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] c);
        return c inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    endfunction

    task automatic run_op(input string nm, input logic [2:0] c,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ez,
                          input logic ei);
        int lat;
        int wt;
        wt = 0;
        while (!bus.in_ready && wt < 20) begin
            tick();
            wt++;
        end
        bus.in_valid    = 1'b1;
        bus.alu_control = c;
        bus.src_a       = a;
        bus.src_b       = b;
        tick();
        bus.in_valid    = 1'b0;
        bus.alu_control = 3'($urandom);
        bus.src_a       = $urandom;
        bus.src_b       = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, W'(lat), W'(NS));
        chk({nm, " result"}, bus.result, er);
        chk({nm, " zero"}, W'(bus.zero), W'(ez));
        chk({nm, " illegal"}, W'(bus.illegal), W'(ei));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, " in_ready after"}, W'(bus.in_ready), 1);
        chk({nm, " out_valid drop"}, W'(bus.out_valid), 0);
    endtask

    vec_t tbl[10];

    initial begin
        logic [2:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic [W-1:0] held;
        int           seen;

        n_chk = 0;
        n_pass = 0;
        tbl[0] = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b1, 1'b0};
        tbl[1] = '{3'b001, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[2] = '{3'b001, 32'd9, 32'd9, 32'h0, 1'b1, 1'b0};
        tbl[3] = '{3'b101, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[4] = '{3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0};
        tbl[5] = '{3'b101, 32'd3, 32'd3, 32'h0, 1'b1, 1'b0};
        tbl[6] = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
        tbl[7] = '{3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
        tbl[8] = '{3'b111, 32'h12345678, 32'h9, 32'h0, 1'b1, 1'b1};
        tbl[9] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0};

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.alu_control = 3'b000;
        bus.src_a       = '0;
        bus.src_b       = '0;
        tick();
        tick();
        chk("rst in_ready", W'(bus.in_ready), 0);
        chk("rst out_valid", W'(bus.out_valid), 0);
        chk("rst result", bus.result, 0);
        chk("rst zero", W'(bus.zero), 0);
        chk("rst illegal", W'(bus.illegal), 0);
        rst_n = 1'b1;
        #1;
        chk("rel in_ready", W'(bus.in_ready), 1);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tbl[i].code, tbl[i].a,
                   tbl[i].b, tbl[i].res, tbl[i].z, tbl[i].ill);

        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom);
            a = $urandom;
            b = (i % 5 == 0) ? a : 32'($urandom);
            if (i % 7 == 0) a = 32'h80000000;
            e = model(c, a, b);
            run_op($sformatf("rnd%0d", i), c, a, b, e, e == 0,
                   !is_legal(c));
        end

        // Backpressure: hold DONE and wiggle ignored inputs
        bus.in_valid    = 1'b1;
        bus.alu_control = 3'b000;
        bus.src_a       = 32'd1;
        bus.src_b       = 32'd2;
        tick();
        bus.in_valid = 1'b0;
        seen = 0;
        while (!bus.out_valid && seen < 20) begin
            tick();
            seen++;
        end
        held = bus.result;
        chk("bp first result", held, 32'd3);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.src_a    = $urandom;
            bus.src_b    = $urandom;
            tick();
            chk("bp result", bus.result, 32'd3);
            chk("bp out_valid", W'(bus.out_valid), 1);
            chk("bp in_ready", W'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp in_ready rise", W'(bus.in_ready), 1);

        // Leave zero/illegal set, then abort a run at slice 2
        run_op("pre-rst", 3'b110, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1);
        bus.in_valid    = 1'b1;
        bus.alu_control = 3'b000;
        bus.src_a       = 32'h11111111;
        bus.src_b       = 32'h11111111;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mid-run partial", W'(bus.result != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("abort result", bus.result, 0);
        chk("abort zero", W'(bus.zero), 0);
        chk("abort illegal", W'(bus.illegal), 0);
        chk("abort out_valid", W'(bus.out_valid), 0);
        chk("abort in_ready", W'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-rst in_ready", W'(bus.in_ready), 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        chk("no stray out_valid", W'(seen), 0);

        run_op("post-rst add", 3'b000, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_slice_exec.md
Name: alu_slice_exec

Overview:
Multi-cycle, bit-serial-by-slice execution unit that consumes the 3-bit ALU control code produced by the datapath's ALU control decoder. It is the receiving end of that control interface. Operands and code are accepted over a valid/ready handshake and processed SLICE bits per cycle, LSB slice first. The result is returned over a second valid/ready handshake. It serves as the area-reduced ALU option for the multi-cycle core variant.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SLICE.
SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE, which must be at least 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and code presented
in_ready  output  1  unit can accept; high only in IDLE with rst_n high
alu_control  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (signed); others illegal
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0, registered alongside result
illegal  output  1  latched code was not one of the five legal codes

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - result, zero, illegal, out_valid, slice counter, and carry are all cleared to 0.
  - in_ready is 0 while rst_n is low.
  - Reset mid-RUN or mid-DONE aborts the operation; no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch src_a, src_b, alu_control; counter = 0; carry = 1 for SUB/SLT, else 0; go to RUN.
- RUN (in_ready = 0):
  - Each cycle processes slice k = bits [k*SLICE +: SLICE].
  - ADD: a + b + carry. SUB/SLT: a + ~b + carry. AND / OR: bitwise.
  - Slice output is written to result[k slice]; carry-out is stored for slice k+1.
  - Counter increments; after slice NSLICE-1, go to DONE.
- Last slice, SLT only:
  - less = diff[WIDTH-1] XOR ovf, where ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
  - result is overwritten with less, zero-extended.
- Illegal code:
  - Same latency as a legal op; result = 0, zero = 1, illegal = 1.
  - illegal is 0 for legal codes.
- zero is computed from the final result and registered on entry to DONE.
- DONE:
  - out_valid = 1; result, zero, and illegal are held stable.
  - On out_ready, go to IDLE.
  - No same-cycle re-accept: in_ready rises the cycle after the output handshake.
- Latency: acceptance at edge t gives out_valid high after edge t + NSLICE. Throughput is at most one op per NSLICE + 2 cycles.
- in_valid, src_*, and alu_control are ignored outside IDLE; the latched copies are used.
- All arithmetic is modulo 2^WIDTH; the final carry-out is discarded.
- result retains its last value in IDLE; out_valid = 0 in IDLE and RUN.

Test Plan:
1. ADD 0xFFFFFFFF + 0x00000001 (WIDTH 32, SLICE 8) -> out_valid exactly 4 cycles after the accept edge; result 0x00000000, zero = 1, illegal = 0.
2. SUB 5 - 7 -> result 0xFFFFFFFE, zero = 0. Then SUB 9 - 9 -> result 0, zero = 1.
3. SLT cases:
   - 0xFFFFFFFF vs 0x00000001 -> result 1.
   - 0x7FFFFFFF vs 0x80000000 (overflow path) -> result 0.
   - 3 vs 3 -> result 0.
4. Bitwise on A = 0xF0F0F0F0, B = 0x0FF00FF0 -> AND gives 0x00F000F0; OR gives 0xFFF0FFF0.
5. Backpressure: hold out_ready low 3 cycles in DONE while toggling in_valid and operands -> result stable, out_valid held, in_ready = 0. Raise out_ready -> in_ready = 1 on the next cycle.
6. Illegal code and reset:
   - Code 3'b111 -> result 0, zero = 1, illegal = 1 after 4 cycles.
   - Pulse rst_n low during RUN slice 2 -> all outputs clear immediately, out_valid never asserts, in_ready = 1 on the first cycle after release.
